// File: rtl/regfile_rd_pkg.sv
// Shared types and constants for the register-file read sequencer.
// Optional feature macro: REGFILE_RD_REPEAT_EN (multi-pass replay).
package regfile_rd_pkg;

  localparam int DATA_W  = 16;
  localparam int DEPTH   = 256;
  localparam int ADDR_W  = 8;
  localparam int COUNT_W = 9;
  localparam int REP_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } rd_state_e;

  function automatic logic [COUNT_W-1:0] clamp_count(
    input logic [COUNT_W-1:0] c
  );
    if (c > COUNT_W'(DEPTH)) return COUNT_W'(DEPTH);
    return c;
  endfunction

endpackage

// File: rtl/regfile_rd_skid.sv
// Two-entry output buffer with fall-through for the word landing this cycle.
// Carries a last-element sideband bit alongside each data word.
module regfile_rd_skid
  import regfile_rd_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              push_last_i,
  input  logic              pop_ready_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic [1:0]        count_o,
  output logic [1:0]        count_next_o
);

  logic [DATA_W-1:0] data_q [2];
  logic [1:0]        last_q;
  logic              rd_ptr_q;
  logic              rd_ptr_d;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic              wr_ptr;
  logic              stored;
  logic              fire;
  logic              deq;
  logic              store;

  always_comb begin
    stored      = count_q != 2'd0;
    out_valid_o = stored || push_i;
    fire        = out_valid_o && pop_ready_i;
    deq         = fire && stored;
    // A landing word consumed straight away never touches storage.
    store       = push_i && !(fire && !stored);
    wr_ptr      = rd_ptr_q ^ count_q[0];
    rd_ptr_d    = rd_ptr_q ^ deq;
    count_d     = count_q + {1'b0, store} - {1'b0, deq};
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
    out_data_o = '0;
    out_last_o = 1'b0;
    if (stored) begin
      out_data_o = data_q[rd_ptr_q];
      out_last_o = last_q[rd_ptr_q];
    end else if (push_i) begin
      out_data_o = push_data_i;
      out_last_o = push_last_i;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q   <= 2'd0;
      rd_ptr_q  <= 1'b0;
      last_q    <= 2'b00;
      data_q[0] <= '0;
      data_q[1] <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      if (store && !flush_i) begin
        data_q[wr_ptr] <= push_data_i;
        last_q[wr_ptr] <= push_last_i;
      end
    end
  end

endmodule

// File: rtl/regfile_index_reader.sv
// Read-side sequencer: walks the register file and streams words out.
// Define REGFILE_RD_REPEAT_EN to add repeat_count multi-pass replay.
module regfile_index_reader
  import regfile_rd_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] fill_count,
`ifdef REGFILE_RD_REPEAT_EN
  input  logic [REP_W-1:0]   repeat_count,
`endif
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  rd_state_e          state_q;
  rd_state_e          state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_d;
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic               infl_q;
  logic               infl_last_q;
  logic               issue;
  logic               issue_last;
  logic [1:0]         skid_cnt;
  logic [1:0]         skid_cnt_nxt;
  logic [2:0]         occ;
  logic               can_issue;
  logic               final_addr;
  logic               rep_more;

`ifdef REGFILE_RD_REPEAT_EN
  logic [REP_W-1:0]   rep_q;
  logic [REP_W-1:0]   rep_d;
  assign rep_more = rep_q != '0;
`else
  assign rep_more = 1'b0;
`endif

  // Buffered words plus the one in flight must fit the two slots.
  assign occ        = {1'b0, skid_cnt} + {2'b00, infl_q};
  assign can_issue  = occ < 3'd2;
  assign final_addr = {1'b0, addr_q} == (cnt_q - COUNT_W'(1));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    issue      = 1'b0;
    issue_last = 1'b0;
`ifdef REGFILE_RD_REPEAT_EN
    rep_d      = rep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = clamp_count(fill_count);
          addr_d  = '0;
`ifdef REGFILE_RD_REPEAT_EN
          rep_d   = repeat_count;
`endif
          state_d = (cnt_d == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (can_issue) begin
          issue = 1'b1;
          if (final_addr) begin
            if (rep_more) begin
              addr_d = '0;
`ifdef REGFILE_RD_REPEAT_EN
              rep_d  = rep_q - REP_W'(1);
`endif
            end else begin
              issue_last = 1'b1;
              state_d    = DRAIN;
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (skid_cnt_nxt == 2'd0) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      issue      = 1'b0;
      issue_last = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
`ifdef REGFILE_RD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      infl_q      <= issue;
      infl_last_q <= issue_last;
`ifdef REGFILE_RD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  regfile_rd_skid u_skid (
    .CLK         (CLK),
    .RESET       (RESET),
    .flush_i     (abort),
    .push_i      (infl_q),
    .push_data_i (rd_data),
    .push_last_i (infl_last_q),
    .pop_ready_i (out_ready),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .count_o     (skid_cnt),
    .count_next_o(skid_cnt_nxt)
  );

  assign rd_en   = issue;
  assign rd_addr = addr_q;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;

endmodule

// File: tb/tb_regfile_index_reader.sv
// Randomized bench for regfile_index_reader against a sequence model.
module tb_regfile_index_reader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic        abort;
  logic [8:0]  fill_count;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef REGFILE_RD_REPEAT_EN
  logic [3:0]  repeat_count;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [15:0] mem [256];
  logic [16:0] got_q [$];
  int          addr_log [$];
  int          done_cnt;
  int          done_cyc;

  always #5 CLK = ~CLK;

  regfile_index_reader dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .start     (start),
    .abort     (abort),
    .fill_count(fill_count),
`ifdef REGFILE_RD_REPEAT_EN
    .repeat_count(repeat_count),
`endif
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  // Register file: data one cycle after the read enable.
  always @(posedge CLK) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: records handshakes, issued addresses, done, and stall holds.
  initial begin
    logic        p_stall;
    logic        p_abort;
    logic [15:0] p_data;
    logic        p_last;
    p_stall  = 1'b0;
    p_abort  = 1'b0;
    p_data   = '0;
    p_last   = 1'b0;
    done_cnt = 0;
    done_cyc = 0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (out_valid && out_ready) got_q.push_back({out_last, out_data});
        if (rd_en) addr_log.push_back(int'(rd_addr));
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (p_stall && !p_abort) begin
          chk("hold_v", 32'(out_valid), 32'd1);
          chk("hold_d", 32'(out_data), 32'(p_data));
          chk("hold_l", 32'(out_last), 32'(p_last));
        end
      end
      p_stall = out_valid && !out_ready && !RESET;
      p_abort = abort;
      p_data  = out_data;
      p_last  = out_last;
    end
  end

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
  endtask

  // mode 0: ready held, 1: toggling, 2: random
  task automatic run_pass(input int n, input int mode, input int rep);
    int ne;
    int total;
    int s;
    int lim;
    ne    = (n > 256) ? 256 : n;
    total = ne * (rep + 1);
    fill_mem();
    got_q.delete();
    addr_log.delete();
    done_cnt   = 0;
    fill_count = 9'(n);
`ifdef REGFILE_RD_REPEAT_EN
    repeat_count = 4'(rep);
`endif
    start     = 1'b1;
    out_ready = 1'b1;
    s = cyc;
    tick();
    start      = 1'b0;
    fill_count = 9'($urandom);
`ifdef REGFILE_RD_REPEAT_EN
    repeat_count = 4'($urandom);
`endif
    for (int i = 0; i < 8000 && done_cnt == 0; i++) begin
      if (mode == 0) out_ready = 1'b1;
      else if (mode == 1) out_ready = (i % 2) == 1;
      else out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    chk("done_n", 32'(done_cnt), 32'd1);
    chk("idle", 32'(busy), 32'd0);
    chk("n_out", 32'(got_q.size()), 32'(total));
    chk("n_rd", 32'(addr_log.size()), 32'(total));
    lim = (got_q.size() < total) ? got_q.size() : total;
    for (int i = 0; i < lim; i++) begin
      logic [16:0] e;
      e = got_q[i];
      chk("data", 32'(e[15:0]), 32'(mem[i % ne]));
      chk("last", 32'(e[16]), 32'(i == total - 1));
    end
    lim = (addr_log.size() < total) ? addr_log.size() : total;
    for (int i = 0; i < lim; i++)
      chk("addr", 32'(addr_log[i]), 32'(i % ne));
    // Ready held: one word per cycle, done two cycles after the last read.
    if (mode == 0)
      chk("done_cyc", 32'(done_cyc - s), (ne == 0) ? 32'd1 : 32'(total + 2));
  endtask

  initial begin
    int rep_max;
    RESET      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    fill_count = '0;
    out_ready  = 1'b1;
`ifdef REGFILE_RD_REPEAT_EN
    repeat_count = '0;
    rep_max      = 3;
`else
    rep_max      = 0;
`endif
    fill_mem();
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_addr", 32'(rd_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    RESET = 1'b0;
    tick();

    run_pass(4, 0, 0);
    run_pass(300, 0, 0);
    run_pass(0, 0, 0);
    run_pass(8, 1, 0);

    // Abort during cycle 3 of a 16-entry pass.
    fill_mem();
    got_q.delete();
    addr_log.delete();
    done_cnt   = 0;
    fill_count = 9'd16;
    start      = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_valid", 32'(out_valid), 32'd0);
    chk("ab_rd_en", 32'(rd_en), 32'd0);
    repeat (5) tick();
    chk("ab_done", 32'(done_cnt), 32'd0);
    for (int i = 0; i < got_q.size(); i++) begin
      logic [16:0] e;
      e = got_q[i];
      chk("ab_data", 32'(e[15:0]), 32'(mem[i]));
    end
    run_pass(2, 0, 0);

    // Asynchronous reset in the middle of a pass.
    done_cnt   = 0;
    fill_count = 9'd50;
    start      = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 RESET = 1'b1;
    #1;
    chk("ar_rd_en", 32'(rd_en), 32'd0);
    chk("ar_addr", 32'(rd_addr), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_data", 32'(out_data), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    tick();
    RESET = 1'b0;
    repeat (3) tick();
    chk("ar_done", 32'(done_cnt), 32'd0);

`ifdef REGFILE_RD_REPEAT_EN
    run_pass(3, 0, 2);
`endif

    for (int k = 0; k < 14; k++) begin
      int sel;
      int n;
      sel = $urandom_range(0, 9);
      if (sel == 0) n = 0;
      else if (sel == 1) n = $urandom_range(257, 511);
      else if (sel == 2) n = 256;
      else n = $urandom_range(1, 40);
      run_pass(n, $urandom_range(0, 2), $urandom_range(0, rep_max));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
